// File: rtl/varray_pkg.sv
// Shared constants and the run record exchanged between varray_writer and varray.
package varray_pkg;
    localparam int VIRTUAL_ELEMENT_WIDTH = 18;
    localparam int VIRTUAL_ADDR_BITS     = 16;
    localparam int MAX_RUN               = 31;
    localparam int RUN_LEN_BITS          = 5;

    typedef struct packed {
        logic [VIRTUAL_ADDR_BITS-1:0]     start;
        logic [RUN_LEN_BITS-1:0]          len;
        logic [VIRTUAL_ELEMENT_WIDTH-1:0] dat;
    } varray_run_t;
endpackage

// File: rtl/varray_writer.sv
// Run-length encoder: merges contiguous equal elements into runs and issues one
// varray write pulse per closed run.
module varray_writer #(
    parameter int VIRTUAL_ELEMENT_WIDTH = varray_pkg::VIRTUAL_ELEMENT_WIDTH,
    parameter int VIRTUAL_ADDR_BITS     = varray_pkg::VIRTUAL_ADDR_BITS,
    parameter int MAX_RUN               = varray_pkg::MAX_RUN,
    parameter int DROP_ZERO             = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [VIRTUAL_ADDR_BITS-1:0]         in_addr,
    input  logic [0:VIRTUAL_ELEMENT_WIDTH-1]     in_dat,
    input  logic                                 flush,
    output logic                                 we,
    output logic [VIRTUAL_ADDR_BITS-1:0]         write_addr,
    output logic [varray_pkg::RUN_LEN_BITS-1:0]  write_addr_len,
    output logic [0:VIRTUAL_ELEMENT_WIDTH-1]     dat_w,
    output logic                                 run_open,
    output logic                                 order_err
);
    import varray_pkg::*;

    typedef struct packed {
        logic [VIRTUAL_ADDR_BITS-1:0]     start;
        logic [RUN_LEN_BITS-1:0]          len;
        logic [VIRTUAL_ELEMENT_WIDTH-1:0] dat;
    } run_t;

    run_t                         run_q, run_n, emit_run;
    logic                         open_q, open_n;
    logic                         close_next_q, close_next_n;
    logic [VIRTUAL_ADDR_BITS-1:0] last_addr_q, last_addr_n;
    logic                         last_valid_q, last_valid_n;
    logic                         order_err_q, order_err_n;
    logic                         emit, accept, valid_elem, top_addr;
    logic [VIRTUAL_ADDR_BITS-1:0] next_addr;

    // Handshake: an element transfers on a rising edge where in_valid && in_ready;
    // in_ready drops only for the cycle that emits the second run of a double close.
    assign in_ready  = !close_next_q;
    assign accept    = in_valid && in_ready;
    assign valid_elem = accept && !(last_valid_q && (in_addr <= last_addr_q));
    assign top_addr  = &in_addr;
    assign next_addr = run_q.start + VIRTUAL_ADDR_BITS'(run_q.len);

    always_comb begin
        run_n        = run_q;
        open_n       = open_q;
        close_next_n = 1'b0;
        last_addr_n  = last_addr_q;
        last_valid_n = last_valid_q;
        order_err_n  = order_err_q;
        emit         = 1'b0;
        emit_run     = run_q;

        if (accept && !valid_elem) begin
            order_err_n = 1'b1;
        end

        if (close_next_q) begin
            emit   = 1'b1;
            open_n = 1'b0;
        end else if (valid_elem) begin
            last_addr_n  = in_addr;
            last_valid_n = 1'b1;
            if ((DROP_ZERO != 0) && (in_dat == '0)) begin
                // Unwritten addresses read back as zero, so a zero only breaks the run.
                if (open_q) begin
                    emit   = 1'b1;
                    open_n = 1'b0;
                end
            end else if (open_q && (in_addr == next_addr) && (in_dat == run_q.dat)) begin
                run_n.len = run_q.len + RUN_LEN_BITS'(1);
                if ((run_n.len == RUN_LEN_BITS'(MAX_RUN)) || top_addr || flush) begin
                    emit     = 1'b1;
                    emit_run = run_n;
                    open_n   = 1'b0;
                end
            end else begin
                run_n.start = in_addr;
                run_n.len   = RUN_LEN_BITS'(1);
                run_n.dat   = in_dat;
                open_n      = 1'b1;
                if (open_q) begin
                    emit         = 1'b1;
                    close_next_n = flush || top_addr;
                end else if (flush || top_addr) begin
                    emit     = 1'b1;
                    emit_run = run_n;
                    open_n   = 1'b0;
                end
            end
        end else if (flush && open_q) begin
            emit   = 1'b1;
            open_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q          <= '0;
            open_q         <= 1'b0;
            close_next_q   <= 1'b0;
            last_addr_q    <= '0;
            last_valid_q   <= 1'b0;
            order_err_q    <= 1'b0;
            we             <= 1'b0;
            write_addr     <= '0;
            write_addr_len <= '0;
            dat_w          <= '0;
        end else begin
            run_q          <= run_n;
            open_q         <= open_n;
            close_next_q   <= close_next_n;
            last_addr_q    <= last_addr_n;
            last_valid_q   <= last_valid_n;
            order_err_q    <= order_err_n;
            we             <= emit;
            write_addr     <= emit ? emit_run.start : '0;
            write_addr_len <= emit ? emit_run.len : '0;
            dat_w          <= emit ? emit_run.dat : '0;
        end
    end

    assign run_open  = open_q;
    assign order_err = order_err_q;
endmodule

// File: tb/tb_varray_writer.sv
// Directed and randomized bench for varray_writer against a run-list reference model.
module tb_varray_writer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_addr = '0;
    logic [0:17] in_dat = '0;
    logic        flush = 1'b0;
    logic        we;
    logic [15:0] write_addr;
    logic [4:0]  write_addr_len;
    logic [0:17] dat_w;
    logic        run_open;
    logic        order_err;

    int checks = 0;
    int errors = 0;

    // Expected writes packed as {addr[15:0], len[4:0], dat[17:0]}.
    logic [38:0] exp_q[$];
    logic        m_open = 1'b0;
    logic [15:0] m_start, m_last;
    int          m_len = 0;
    logic [17:0] m_dat;
    logic        m_have_last = 1'b0;
    logic        exp_err = 1'b0;

    varray_writer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_dat(in_dat), .flush(flush), .we(we),
        .write_addr(write_addr), .write_addr_len(write_addr_len), .dat_w(dat_w),
        .run_open(run_open), .order_err(order_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_close();
        if (m_open) exp_q.push_back({m_start, 5'(m_len), m_dat});
        m_open = 1'b0;
    endtask

    // Reference: each element either extends the current run or starts a new one.
    task automatic model_elem(input logic [15:0] a, input logic [17:0] d, input logic fl);
        if (m_have_last && a <= m_last) begin
            exp_err = 1'b1;
            if (fl) m_close();
            return;
        end
        m_last = a;
        m_have_last = 1'b1;
        if (d == 0) begin
            m_close();
            return;
        end
        if (m_open && (int'(a) == int'(m_start) + m_len) && d == m_dat) begin
            m_len++;
        end else begin
            m_close();
            m_open = 1'b1; m_start = a; m_len = 1; m_dat = d;
        end
        if (m_len == 31 || a == 16'hffff || fl) m_close();
    endtask

    task automatic step(input logic v, input logic [15:0] a, input logic [17:0] d, input logic fl);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        while (v && !in_ready && guard < 4) begin
            @(negedge clk);
            guard++;
        end
        if (v) chk("in_ready_wait", in_ready, 1);
        in_valid = v; in_addr = a; in_dat = d; flush = fl;
        if (v) model_elem(a, d, fl);
        else if (fl) m_close();
    endtask

    task automatic settle();
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("rst_we", we, 0);
        chk("rst_addr", write_addr, 0);
        chk("rst_len", write_addr_len, 0);
        chk("rst_dat", dat_w, 0);
        chk("rst_open", run_open, 0);
        chk("rst_err", order_err, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_pending", exp_q.size(), 0);
        reset = 1'b0;
        m_open = 1'b0; m_have_last = 1'b0; exp_err = 1'b0;
    endtask

    task automatic chk_write(input string tag, input logic [15:0] a, input int l, input logic [17:0] d);
        chk({tag, "_we"}, we, 1);
        chk({tag, "_wr"}, {write_addr, write_addr_len, dat_w}, {a, 5'(l), d});
    endtask

    always @(negedge clk) begin
        if (we) begin
            chk("unexpected_write", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("write_stream", {write_addr, write_addr_len, dat_w}, exp_q.pop_front());
        end
    end

    initial begin
        int cur;
        logic [17:0] d;
        do_reset();

        // Contiguous equal run closed by flush.
        for (int i = 0; i < 4; i++) step(1, 16'(i), 18'h5, 0);
        step(1, 16'd4, 18'h5, 1);
        chk("t1_open", run_open, 1);
        settle();
        chk_write("t1", 16'd0, 5, 18'h5);
        settle();
        chk("t1_closed", run_open, 0);

        // Data mismatch closes on consecutive cycles.
        step(1, 16'd10, 18'h7, 0);
        step(1, 16'd11, 18'h9, 0);
        step(0, 16'd0, 18'h0, 1);
        chk_write("t2a", 16'd10, 1, 18'h7);
        chk("t2_ready_a", in_ready, 1);
        settle();
        chk_write("t2b", 16'd11, 1, 18'h9);
        chk("t2_ready_b", in_ready, 1);

        // Max run length.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            step(1, 16'(i), 18'h3, 0);
            if (i == 31) chk_write("t3a", 16'd0, 31, 18'h3);
        end
        step(0, 16'd0, 18'h0, 1);
        settle();
        chk_write("t3b", 16'd31, 9, 18'h3);

        // Dropped zero element splits runs.
        do_reset();
        step(1, 16'd0, 18'h1, 0);
        step(1, 16'd1, 18'h0, 0);
        step(1, 16'd2, 18'h1, 0);
        chk_write("t4a", 16'd0, 1, 18'h1);
        step(0, 16'd0, 18'h0, 1);
        chk("t4_no_zero_write", we, 0);
        settle();
        chk_write("t4b", 16'd2, 1, 18'h1);

        // Mismatch together with flush: double close.
        do_reset();
        for (int i = 20; i < 23; i++) step(1, 16'(i), 18'h4, 0);
        step(1, 16'd23, 18'h8, 1);
        settle();
        chk_write("t5a", 16'd20, 3, 18'h4);
        chk("t5_ready_low", in_ready, 0);
        settle();
        chk_write("t5b", 16'd23, 1, 18'h8);
        chk("t5_ready_back", in_ready, 1);
        chk("t5_closed", run_open, 0);

        // Repeated address is an order error; then reset discards the open run.
        do_reset();
        step(1, 16'd5, 18'h1, 0);
        step(1, 16'd5, 18'h2, 0);
        settle();
        chk("t6_order_err", order_err, 1);
        chk("t6_open", run_open, 1);
        chk("t6_no_write", we, 0);
        do_reset();
        settle();
        chk("t6_post_rst_we", we, 0);

        // Randomized element stream.
        cur = 0;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                step(0, 16'd0, 18'h0, 1'($urandom_range(0, 1)));
            end else begin
                d = ($urandom_range(0, 6) == 0) ? 18'h0 : 18'($urandom_range(1, 2));
                step(1, 16'(cur), d, $urandom_range(0, 9) == 0);
                cur += ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 2);
            end
        end
        step(0, 16'd0, 18'h0, 1);
        for (int i = 0; i < 3; i++) settle();
        chk("rand_pending", exp_q.size(), 0);
        chk("rand_order_err", order_err, exp_err);

        // Run reaching the top address closes without wrapping.
        do_reset();
        for (int i = 16'hfff0; i <= 16'hffff; i++) step(1, 16'(i), 18'h6, 0);
        settle();
        chk_write("top", 16'hfff0, 16, 18'h6);
        for (int i = 0; i < 3; i++) settle();
        chk("top_pending", exp_q.size(), 0);
        chk("top_closed", run_open, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
